// File: rtl/mcu_bus_initiator.sv
// Host-side master for the 8-bit MCU parallel bus: turns one local request at a
// time into strobed bus beats and, for GET_ID, reads back the responder's ID byte.
module mcu_bus_initiator #(
   parameter int         HALF_PERIOD      = 2,
   parameter int         TURNAROUND_BEATS = 2,
   parameter logic [7:0] CMD_GET_ID       = 8'h01,
   parameter logic [7:0] CMD_SET_ADDRESS  = 8'h02
) (
   input  logic        system_clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_kind,
   input  logic [31:0] req_address,
   input  logic [7:0]  req_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        busy,
   output logic        bus_clock,
   output logic        bus_command_data,
   output logic [7:0]  bus_out,
   output logic        bus_oe,
   input  logic [7:0]  bus_in
);

   // Handshake: a request transfers on any rising edge where req_valid and
   // req_ready are both high; req_* are latched there and later changes are ignored.

   typedef enum logic [1:0] {S_IDLE, S_BEAT_LOW, S_BEAT_HIGH} state_t;

   localparam logic [1:0] K_GET_ID      = 2'd0;
   localparam logic [1:0] K_SET_ADDRESS = 2'd1;
   localparam logic [1:0] K_WRITE_DATA  = 2'd2;

   localparam int            PW          = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [PW-1:0] PHASE_LAST  = PW'(HALF_PERIOD - 1);
   localparam logic [2:0]    TA_LAST     = 3'(TURNAROUND_BEATS);
   localparam logic [2:0]    GET_ID_LAST = 3'(TURNAROUND_BEATS + 1);

   state_t        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [2:0]    beat_q, beat_d;
   logic [1:0]    kind_q, kind_d;
   logic [31:0]   addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [7:0]    rsp_data_q, rsp_data_d;
   logic          bclk_q, bclk_d;
   logic          cd_q, cd_d;
   logic [7:0]    out_q, out_d;
   logic          oe_q, oe_d;

   logic [1:0]  sel_kind;
   logic [2:0]  sel_beat;
   logic [31:0] sel_addr;
   logic [7:0]  sel_data;
   logic        nx_cd, nx_oe;
   logic [7:0]  nx_out;
   logic        last_beat;

   // Content of the beat about to start: beat 0 from the live request, else the next beat.
   always_comb begin
      if (state_q == S_IDLE) begin
         sel_kind = req_kind;
         sel_beat = 3'd0;
         sel_addr = req_address;
         sel_data = req_data;
      end else begin
         sel_kind = kind_q;
         sel_beat = beat_q + 3'd1;
         sel_addr = addr_q;
         sel_data = data_q;
      end
      nx_cd  = 1'b0;
      nx_oe  = 1'b1;
      nx_out = 8'h00;
      case (sel_kind)
         K_GET_ID: begin
            if (sel_beat == 3'd0) begin
               nx_out = CMD_GET_ID;
            end else if (sel_beat <= TA_LAST) begin
               nx_oe = 1'b0;
            end else begin
               nx_cd = 1'b1;
               nx_oe = 1'b0;
            end
         end
         K_SET_ADDRESS: begin
            case (sel_beat)
               3'd0:    nx_out = CMD_SET_ADDRESS;
               3'd1:    begin nx_cd = 1'b1; nx_out = sel_addr[31:24]; end
               3'd2:    begin nx_cd = 1'b1; nx_out = sel_addr[23:16]; end
               3'd3:    begin nx_cd = 1'b1; nx_out = sel_addr[15:8];  end
               default: begin nx_cd = 1'b1; nx_out = sel_addr[7:0];   end
            endcase
         end
         K_WRITE_DATA: begin
            nx_cd  = 1'b1;
            nx_out = sel_data;
         end
         default: nx_out = sel_data;
      endcase
   end

   always_comb begin
      last_beat = 1'b1;
      case (kind_q)
         K_GET_ID:      last_beat = (beat_q == GET_ID_LAST);
         K_SET_ADDRESS: last_beat = (beat_q == 3'd4);
         default:       last_beat = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      beat_d      = beat_q;
      kind_d      = kind_q;
      addr_d      = addr_q;
      data_d      = data_q;
      ready_d     = ready_q;
      busy_d      = busy_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      bclk_d      = bclk_q;
      cd_d        = cd_q;
      out_d       = out_q;
      oe_d        = oe_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && ready_q) begin
               state_d = S_BEAT_LOW;
               phase_d = '0;
               beat_d  = 3'd0;
               kind_d  = req_kind;
               addr_d  = req_address;
               data_d  = req_data;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               bclk_d  = 1'b0;
               cd_d    = nx_cd;
               out_d   = nx_out;
               oe_d    = nx_oe;
            end
         end
         S_BEAT_LOW: begin
            if (phase_q == PHASE_LAST) begin
               state_d = S_BEAT_HIGH;
               phase_d = '0;
               bclk_d  = 1'b1;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         S_BEAT_HIGH: begin
            if (phase_q != PHASE_LAST) begin
               phase_d = phase_q + PW'(1);
            end else if (last_beat) begin
               state_d = S_IDLE;
               phase_d = '0;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               bclk_d  = 1'b0;
               cd_d    = 1'b0;
               out_d   = 8'h00;
               oe_d    = 1'b0;
               if (kind_q == K_GET_ID) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = bus_in;
               end
            end else begin
               state_d = S_BEAT_LOW;
               phase_d = '0;
               beat_d  = beat_q + 3'd1;
               bclk_d  = 1'b0;
               cd_d    = nx_cd;
               out_d   = nx_out;
               oe_d    = nx_oe;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         phase_q     <= '0;
         beat_q      <= 3'd0;
         kind_q      <= 2'd0;
         addr_q      <= 32'd0;
         data_q      <= 8'd0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'd0;
         bclk_q      <= 1'b0;
         cd_q        <= 1'b0;
         out_q       <= 8'd0;
         oe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         beat_q      <= beat_d;
         kind_q      <= kind_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         bclk_q      <= bclk_d;
         cd_q        <= cd_d;
         out_q       <= out_d;
         oe_q        <= oe_d;
      end
   end

   assign req_ready        = ready_q;
   assign busy             = busy_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_data         = rsp_data_q;
   assign bus_clock        = bclk_q;
   assign bus_command_data = cd_q;
   assign bus_out          = out_q;
   assign bus_oe           = oe_q;

endmodule
